// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame path.
package uart_tx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the data phase of a UART frame.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  next_bit,
    output logic                  done
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign done = shift_en && (cnt_q == CW'(DATA_WIDTH - 1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            cnt_d   = done ? '0 : cnt_q + 1'b1;
        end
    end

    // Post-update LSB: the bit that goes on the line after this edge.
    assign next_bit = shift_d[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one bit per CLK, start + data (LSB first) + optional parity + stop.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e state_q, state_d;
    logic      par_en_q, par_en_d;
    logic      par_bit_q, par_bit_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      accept;
    logic      ser_next_bit;
    logic      ser_done;

    assign accept = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk      (CLK),
        .rst      (RST),
        .load     (accept),
        .shift_en (state_q == DATA),
        .load_data(P_DATA),
        .next_bit (ser_next_bit),
        .done     (ser_done)
    );

    always_comb begin
        state_d   = state_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        if (accept) begin
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        end
        unique case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = DATA;
            DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each bit appears at its own edge.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = ser_next_bit;
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: per-cycle expected {TX_OUT, Busy} pairs.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic tx;
        logic busy;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       exp_par;
    } vec_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bit(input logic tx, input logic busy);
        exp_t e;
        e.tx   = tx;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic with_idle);
        push_bit(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) push_bit(d[i], 1'b1);
        if (par_en) push_bit(par_bit, 1'b1);
        push_bit(1'b1, 1'b1);
        if (with_idle) push_bit(1'b1, 1'b0);
    endtask

    // Advance one edge and compare against the head of the scoreboard.
    task automatic step(input string name);
        exp_t e;
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got tx=%b busy=%b", name, TX_OUT, Busy);
        end else begin
            e = exp_q.pop_front();
            chk({name, ".tx"}, TX_OUT, e.tx);
            chk({name, ".busy"}, Busy, e.busy);
        end
    endtask

    task automatic drain(input string name);
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 64) begin
            step(name);
            guard++;
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hB3, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b1};

        RST        = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Reset held with a pending request: line stays idle.
        for (int i = 0; i < 3; i++) begin
            push_bit(1'b1, 1'b0);
            step("reset");
        end
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        push_bit(1'b1, 1'b0);
        step("post_reset_idle");

        // Table-driven single frames, each followed by one idle cycle.
        for (int v = 0; v < 6; v++) begin
            P_DATA     = vecs[v].data;
            PAR_EN     = vecs[v].par_en;
            PAR_TYP    = vecs[v].par_typ;
            DATA_VALID = 1'b1;
            push_frame(vecs[v].data, vecs[v].par_en, vecs[v].exp_par, 1'b1);
            step($sformatf("vec%0d_start", v));
            DATA_VALID = 1'b0;
            P_DATA     = ~vecs[v].data;
            PAR_TYP    = ~vecs[v].par_typ;
            drain($sformatf("vec%0d", v));
        end

        // Back-to-back 0x55 then 0x0F, second request during the stop bit.
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0, 1'b0);
        push_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        step("b2b_f1");
        DATA_VALID = 1'b0;
        for (int i = 0; i < 9; i++) step("b2b_f1");
        P_DATA     = 8'h0F;
        DATA_VALID = 1'b1;
        step("b2b_f2_start");
        DATA_VALID = 1'b0;
        drain("b2b_f2");

        // Request with 0xFF during data bits of a 0x00 frame is ignored.
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        push_frame(8'h00, 1'b0, 1'b0, 1'b1);
        step("ignore_start");
        DATA_VALID = 1'b0;
        step("ignore");
        step("ignore");
        P_DATA     = 8'hFF;
        DATA_VALID = 1'b1;
        step("ignore");
        step("ignore");
        step("ignore");
        DATA_VALID = 1'b0;
        drain("ignore");

        // Reset asserted while data bit 4 is on the line.
        P_DATA     = 8'h00;
        DATA_VALID = 1'b1;
        push_bit(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) push_bit(1'b0, 1'b1);
        step("midrst_start");
        DATA_VALID = 1'b0;
        for (int i = 0; i < 5; i++) step("midrst_data");
        RST = 1'b1;
        push_bit(1'b1, 1'b0);
        step("midrst_abort");
        RST = 1'b0;
        push_bit(1'b1, 1'b0);
        push_bit(1'b1, 1'b0);
        drain("midrst_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmitter that serializes one parallel byte per request into a standard asynchronous frame: start bit, 8 data bits LSB first, optional even/odd parity bit, and one stop bit. It is the transmit-side counterpart of the UART receiver in the UART block. It runs on the TX bit clock, so each CLK cycle is exactly one bit period; baud division is done upstream by the clock divider. Parallel data arrives from the system controller and TX_OUT drives the serial line.

## Interface
- DATA_WIDTH, 8, payload bits per frame.
- CLK  input  1  TX bit clock; one serial bit per cycle.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  byte to send; sampled only on acceptance.
- DATA_VALID  input  1  request; acceptance rules are under Operation.
- PAR_EN  input  1  1 = parity bit inserted; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- TX_OUT  output  1  serial line, registered; idles high.
- Busy  output  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (RST high at a CLK edge): state = IDLE, TX_OUT = 1, Busy = 0, shift register and bit counter = 0. Reset mid-frame aborts the frame immediately; nothing is resumed.
- Acceptance: a request is accepted at an edge where DATA_VALID = 1 and state is IDLE or STOP.
  - On acceptance, P_DATA, PAR_EN and PAR_TYP are latched.
  - The parity bit is computed from the latched byte at latch time: even = XOR of the data bits; odd = the inverse of that.
- DATA_VALID in START, DATA or PARITY is ignored and not queued. P_DATA changes after acceptance do not affect the frame.
- Transitions:
  - IDLE to START on acceptance.
  - START to DATA after 1 cycle.
  - DATA runs for DATA_WIDTH cycles, shifting LSB first. The bit counter counts 0 to DATA_WIDTH-1.
  - After DATA, go to PARITY if the latched PAR_EN = 1, otherwise go to STOP.
  - PARITY to STOP after 1 cycle.
  - STOP to START on acceptance (back-to-back frames), otherwise to IDLE.
- TX_OUT per state: IDLE = 1, START = 0, DATA = current LSB, PARITY = parity bit, STOP = 1.
- Busy = 1 in every state except IDLE.

## Timing
- Acceptance at edge N:
  - Start bit on TX_OUT during cycle N to N+1, and Busy rises at edge N.
  - Data bit i is driven from edge N+1+i.
  - Parity bit is driven from edge N+9.
  - Stop bit is driven from edge N+10 with parity, or N+9 without.
- Frame length is 11 cycles with parity, 10 without.
- Busy falls at the edge that ends the stop bit, unless a new request is accepted at that edge.
- Back-to-back: acceptance during the STOP cycle makes the next start bit follow the stop bit with no idle gap. Busy stays high across both frames.
- Outputs are registered only: no combinational path from any input to TX_OUT or Busy.
- Widths:
  - Bit counter is clog2(DATA_WIDTH) bits and wraps to 0 on leaving DATA.
  - No other arithmetic.

## Structure
- Package uart_tx_pkg holds:
  - the state enum typedef (binary encoding, IDLE = 0);
  - DATA_WIDTH_DEF = 8;
  - parity-type constants PAR_EVEN = 0 and PAR_ODD = 1.
- Sub-module uart_tx_serializer holds:
  - the load/shift register and the bit counter;
  - a done flag asserted on the last data bit.
- The top level holds the FSM, the parity latch and the output mux/register.

## Test plan
- Reset with RST held high for 3 cycles, DATA_VALID = 1 throughout -> TX_OUT = 1, Busy = 0, and no frame starts until after RST is released.
- 0xA5, PAR_EN = 0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles), then idle high; Busy high for exactly 10 cycles.
- 0xB3, PAR_EN = 1, PAR_TYP = 0 -> 0,1,1,0,0,1,1,0,1,1,1: even parity bit = 1, 11 cycles.
- 0x03, PAR_EN = 1, PAR_TYP = 1 -> 0,1,1,0,0,0,0,0,0,1,1: odd parity bit = 1.
- Back-to-back 0x55 then 0x0F (no parity), with the second DATA_VALID pulsed in the STOP cycle -> 20 continuous bits with no idle gap, and Busy never drops.
- Mid-frame checks:
  - DATA_VALID with 0xFF pulsed during the DATA bits of a 0x00 frame -> frame unchanged, 0xFF never sent.
  - RST asserted at data bit 4 -> TX_OUT = 1 and Busy = 0 at the next edge.
